// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Transmit-side driver for an output-stationary NxN int8 MAC systolic array.
//   Takes one A-column / B-row operand vector per handshake. It feeds them
//   into per-lane shift chains that skew the streams diagonally. It issues a
//   one-cycle array flush before each job. After the K-th operand it drains
//   the array with 2N cycles of zero injection and then pulses done.
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   start, k_len       job start pulse (IDLE only) and reduction length K
//   busy, done         high outside IDLE; one-cycle completion pulse
//   in_valid/in_ready  operand handshake; in_a = A[*][k], in_b = B[k][*]
//   flush              clears array accumulators and pipeline registers
//   west_data          lane i -> in_west of array row i, column 0
//   north_data         lane j -> in_north of array column j, row 0
//   stall_cnt          (only with SYSTOLIC_FEEDER_STALL_CNT_EN) saturating
//                      count of FEED cycles with in_valid low
//
// Build option: define SYSTOLIC_FEEDER_STALL_CNT_EN to add stall_cnt.
module systolic_feeder #(
  parameter int N  = 4,
  parameter int KW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [KW-1:0]  k_len,
  output logic           busy,
  output logic           done,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*8-1:0] in_a,
  input  logic [N*8-1:0] in_b,
  output logic           flush,
  output logic [N*8-1:0] west_data,
  output logic [N*8-1:0] north_data
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]    stall_cnt
`endif
);

  localparam int DW = $clog2(2 * N) + 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(2 * N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   feed_cnt_q, feed_cnt_d;
  logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
  logic            accept;
  logic            clear_skew;
  logic [N*8-1:0]  inj_a;
  logic [N*8-1:0]  inj_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      feed_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      feed_cnt_q  <= feed_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    feed_cnt_d  = feed_cnt_q;
    drain_cnt_d = drain_cnt_q;
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    in_ready    = 1'b0;
    flush       = 1'b0;
    accept      = 1'b0;
    clear_skew  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          k_d     = k_len;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        flush       = 1'b1;
        clear_skew  = 1'b1;
        feed_cnt_d  = '0;
        drain_cnt_d = '0;
        state_d     = (k_q == '0) ? S_DONE : S_FEED;
      end
      S_FEED: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          feed_cnt_d = feed_cnt_q + KW'(1);
          if (feed_cnt_q + KW'(1) == k_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Zero vectors keep flowing in (accept is low) while the last
        // wavefront reaches PE(N-1,N-1).
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Any cycle without an accept injects a zero vector, so stalls become
  // bubbles in both chains and the diagonal alignment is kept.
  assign inj_a = accept ? in_a : '0;
  assign inj_b = accept ? in_b : '0;

  // Lane gi is a (gi+1)-stage shift chain: a value accepted at edge t
  // appears on the lane output after edge t+gi.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [7:0] west_q  [0:gi];
    logic [7:0] west_d  [0:gi];
    logic [7:0] north_q [0:gi];
    logic [7:0] north_d [0:gi];

    always_comb begin
      west_d[0]  = clear_skew ? 8'h00 : inj_a[gi*8 +: 8];
      north_d[0] = clear_skew ? 8'h00 : inj_b[gi*8 +: 8];
      for (int s = 1; s <= gi; s++) begin
        west_d[s]  = clear_skew ? 8'h00 : west_q[s-1];
        north_d[s] = clear_skew ? 8'h00 : north_q[s-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s <= gi; s++) begin
          west_q[s]  <= 8'h00;
          north_q[s] <= 8'h00;
        end
      end else begin
        for (int s = 0; s <= gi; s++) begin
          west_q[s]  <= west_d[s];
          north_q[s] <= north_d[s];
        end
      end
    end

    assign west_data[gi*8 +: 8]  = west_q[gi];
    assign north_data[gi*8 +: 8] = north_q[gi];
  end

`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Cleared at the start of each job; holds after FEED until the next FLUSH.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_FLUSH) begin
      stall_cnt_d = '0;
    end else if ((state_q == S_FEED) && !in_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder
//   Bench for systolic_feeder. A monitor samples the DUT at every falling
//   edge and keeps a behavioural NxN output-stationary MAC array driven by
//   west_data/north_data. After each job the array sums are compared with the
//   plain matrix product A*B. The bench also compares the handshake, flush,
//   done and busy timing with cycle counts derived from K and the injected
//   stalls.
//   With SYSTOLIC_FEEDER_STALL_CNT_EN defined it also checks stall_cnt.
`timescale 1ns/1ps
module tb_systolic_feeder;
  localparam int N    = 4;
  localparam int KW   = 8;
  localparam int KMAX = 8;
  localparam int HIST = 4096;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [KW-1:0]  k_len = '0;
  logic           busy;
  logic           done;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*8-1:0] in_a = '0;
  logic [N*8-1:0] in_b = '0;
  logic           flush;
  logic [N*8-1:0] west_data;
  logic [N*8-1:0] north_data;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [15:0]    stall_cnt;
`endif

  systolic_feeder #(.N(N), .KW(KW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .k_len      (k_len),
    .busy       (busy),
    .done       (done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .west_data  (west_data),
    .north_data (north_data)
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sx(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // ---------------- monitor + behavioural array ----------------
  int         cyc = 0;
  int         done_cnt = 0;
  int         last_done_cyc = -1;
  int         flush_cnt = 0;
  int         last_flush_cyc = -1;
  int         rdy_cnt = 0;
  int         busy_cnt = 0;
  int         nz_cnt = 0;
  int         acc_cnt = 0;
  logic [7:0] w_hist [HIST][N];
  logic [7:0] n_hist [HIST][N];
  longint     pe_acc [N][N];

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) pe_acc[i][j] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        w_hist[cyc % HIST][i] = west_data[i*8 +: 8];
        n_hist[cyc % HIST][i] = north_data[i*8 +: 8];
      end
      if (done) begin done_cnt++; last_done_cyc = cyc; end
      if (flush) begin flush_cnt++; last_flush_cyc = cyc; end
      if (in_ready) rdy_cnt++;
      if (busy) busy_cnt++;
      if (in_valid && in_ready) acc_cnt++;
      if (west_data != '0 || north_data != '0) nz_cnt++;
      // PE(i,j) sees west lane i delayed by j columns and north lane j
      // delayed by i rows.
      if (flush) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) pe_acc[i][j] = 0;
      end else begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if (cyc - j >= 0 && cyc - i >= 0)
              pe_acc[i][j] += longint'(sx(w_hist[(cyc - j) % HIST][i]) *
                                      sx(n_hist[(cyc - i) % HIST][j]));
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] job_a [N][KMAX];
  logic [7:0] job_b [KMAX][N];
  int         job_stall [KMAX];
  int         job_id = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stalls();
    for (int k = 0; k < KMAX; k++) job_stall[k] = 0;
  endtask

  task automatic fill_random(input int max_stall);
    for (int k = 0; k < KMAX; k++) begin
      for (int i = 0; i < N; i++) begin
        job_a[i][k] = 8'($urandom);
        job_b[k][i] = 8'($urandom);
      end
      job_stall[k] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, max_stall)) : 0;
    end
  endtask

  task automatic run_job(input int K, input bit stray);
    int     s_cyc, tot_stall, exp_done, done_seen;
    int     b_done, b_flush, b_rdy, b_busy, b_nz, b_acc;
    int     acc_cyc [KMAX];
    longint exp_c;
    string  tg;
    tot_stall = 0;
    step();
    start = 1'b1; k_len = KW'(K); in_valid = 1'b0; s_cyc = cyc;
    b_done = done_cnt; b_flush = flush_cnt; b_rdy = rdy_cnt;
    b_busy = busy_cnt; b_nz = nz_cnt; b_acc = acc_cnt;
    step();
    start = 1'b0;
    for (int k = 0; k < K; k++) begin
      for (int s = 0; s < job_stall[k]; s++) begin
        step();
        start = 1'b0; in_valid = 1'b0;
        tot_stall++;
      end
      step();
      in_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        in_a[i*8 +: 8] = job_a[i][k];
        in_b[i*8 +: 8] = job_b[k][i];
      end
      if (stray && k == 1) begin
        start = 1'b1; k_len = KW'(K + 4);
      end else begin
        start = 1'b0;
      end
      acc_cyc[k] = cyc;
      @(negedge clk);
      check_eq($sformatf("job%0d in_ready k%0d", job_id, k), longint'(in_ready), 1);
    end
    step();
    start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    done_seen = 0;
    for (int t = 0; t < 200 && done_seen == 0; t++) begin
      if (done_cnt != b_done) done_seen = 1;
      else step();
    end
    if (done_seen == 0) begin
      check_eq($sformatf("job%0d done_timeout", job_id), 0, 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      job_id++;
      return;
    end
    repeat (3) step();
    exp_done = (K == 0) ? s_cyc + 2 : acc_cyc[K-1] + 2 * N + 1;
    check_eq($sformatf("job%0d done_count", job_id), done_cnt - b_done, 1);
    check_eq($sformatf("job%0d done_cycle", job_id), last_done_cyc, exp_done);
    check_eq($sformatf("job%0d flush_count", job_id), flush_cnt - b_flush, 1);
    check_eq($sformatf("job%0d flush_cycle", job_id), last_flush_cyc, s_cyc + 1);
    check_eq($sformatf("job%0d in_ready_cycles", job_id), rdy_cnt - b_rdy, K + tot_stall);
    check_eq($sformatf("job%0d accepts", job_id), acc_cnt - b_acc, K);
    check_eq($sformatf("job%0d busy_cycles", job_id), busy_cnt - b_busy, exp_done - s_cyc);
    check_eq($sformatf("job%0d busy_after", job_id), longint'(busy), 0);
    if (K == 0) check_eq($sformatf("job%0d data_nonzero", job_id), nz_cnt - b_nz, 0);
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    check_eq($sformatf("job%0d stall_cnt", job_id), longint'(stall_cnt), tot_stall);
`endif
    for (int k = 0; k < K; k++)
      for (int i = 0; i < N; i++) begin
        tg = $sformatf("job%0d west[%0d] k%0d", job_id, i, k);
        check_eq(tg, longint'(w_hist[(acc_cyc[k] + 1 + i) % HIST][i]), longint'(job_a[i][k]));
        tg = $sformatf("job%0d north[%0d] k%0d", job_id, i, k);
        check_eq(tg, longint'(n_hist[(acc_cyc[k] + 1 + i) % HIST][i]), longint'(job_b[k][i]));
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_c = 0;
        for (int k = 0; k < K; k++) exp_c += longint'(sx(job_a[i][k]) * sx(job_b[k][j]));
        check_eq($sformatf("job%0d C[%0d][%0d]", job_id, i, j), pe_acc[i][j], exp_c);
      end
    $display("job %0d: K=%0d stalls=%0d stray_start=%0d start@%0d done@%0d",
             job_id, K, tot_stall, stray, s_cyc, last_done_cyc);
    job_id++;
  endtask

  task automatic check_outputs_zero(input string tg);
    check_eq({tg, " busy"}, longint'(busy), 0);
    check_eq({tg, " done"}, longint'(done), 0);
    check_eq({tg, " in_ready"}, longint'(in_ready), 0);
    check_eq({tg, " flush"}, longint'(flush), 0);
    check_eq({tg, " west_data"}, longint'(west_data), 0);
    check_eq({tg, " north_data"}, longint'(north_data), 0);
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    check_eq({tg, " stall_cnt"}, longint'(stall_cnt), 0);
`endif
  endtask

  task automatic reset_mid_job();
    int b_done;
    b_done = done_cnt;
    step();
    start = 1'b1; k_len = KW'(5);
    step();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      in_valid = 1'b1; in_a = 32'h11223344; in_b = 32'h55667788;
    end
    step();
    in_valid = 1'b0;
    #2;
    check_eq("midreset busy_before", longint'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    in_a = '0; in_b = '0;
    repeat (20) step();
    check_eq("midreset no_done", done_cnt - b_done, 0);
    check_eq("midreset busy_after", longint'(busy), 0);
    $display("reset during FEED: K=5 after 2 accepts, released, idle for 20 cycles");
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // A = [[1,2],[3,4],[5,6],[7,8]], B rows [1,0,0,0] and [0,1,0,0]
    clear_stalls();
    for (int i = 0; i < N; i++) begin
      job_a[i][0] = 8'(2 * i + 1);
      job_a[i][1] = 8'(2 * i + 2);
      job_b[0][i] = (i == 0) ? 8'd1 : 8'd0;
      job_b[1][i] = (i == 1) ? 8'd1 : 8'd0;
    end
    run_job(2, 1'b0);
    job_stall[1] = 3;
    run_job(2, 1'b0);

    clear_stalls();
    run_job(0, 1'b0);

    fill_random(1);
    run_job(3, 1'b1);

    clear_stalls();
    for (int i = 0; i < N; i++) begin
      job_a[i][0] = 8'h80;
      job_b[0][i] = 8'h80;
    end
    run_job(1, 1'b0);

    reset_mid_job();

    for (int r = 0; r < 8; r++) begin
      fill_random(3);
      run_job(int'($urandom_range(1, KMAX)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
